// File: rtl/tone_meter_if.sv
// Signal bundle between a square-wave tone source and the tone_meter listener.
// The slave modport is the meter side; the master modport is the source/observer side.
interface tone_meter_if #(
  parameter int EC_W = 16
);
  logic            tone_in;
  logic [17:0]     half_period;
  logic            meas_valid;
  logic            stable;
  logic            silent;
  logic            note_a;
  logic [EC_W-1:0] edge_count;

  modport master (
    output tone_in,
    input  half_period, meas_valid, stable, silent, note_a, edge_count
  );

  modport slave (
    input  tone_in,
    output half_period, meas_valid, stable, silent, note_a, edge_count
  );
endinterface

// File: rtl/tone_meter.sv
// Measures the edge-to-edge half-period of an asynchronous square wave and flags
// stable tone, silence and concert-A pitch.
module tone_meter #(
  parameter int TIMEOUT   = 262143,
  parameter int TOL       = 64,
  parameter int NOTE_HALF = 113636,
  parameter int NOTE_TOL  = 1136,
  parameter int EC_W      = 16
) (
  input logic         clk,
  input logic         rst,
  tone_meter_if.slave bus
);
  localparam int CW = 18;

  typedef enum logic [1:0] {
    ST_SILENT,
    ST_ARMED,
    ST_MEASURING
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_s1, r_s2, r_s3;
  logic            w_edge;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_prev;
  logic [CW-1:0]   r_half;
  logic            r_valid;
  logic            r_stable;
  logic            r_silent;
  logic            r_note;
  logic [EC_W-1:0] r_edges;
  logic            w_at_limit;
  logic            w_measure;
  logic            w_check_tol;
  logic            w_timeout;
  logic [CW-1:0]   w_diff_prev;
  logic [CW-1:0]   w_diff_note;
  logic            w_new_stable;
  logic            w_in_window;

  // One pulse per transition in either direction, taken after the 2-flop synchronizer.
  assign w_edge     = r_s2 ^ r_s3;
  assign w_at_limit = (r_cnt == CW'(TIMEOUT));

  // Ordered subtraction keeps the magnitude exact without a signed intermediate.
  assign w_diff_prev  = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
  assign w_diff_note  = (r_cnt >= CW'(NOTE_HALF)) ? (r_cnt - CW'(NOTE_HALF))
                                                  : (CW'(NOTE_HALF) - r_cnt);
  assign w_new_stable = w_check_tol && (w_diff_prev <= CW'(TOL));
  assign w_in_window  = (w_diff_note <= CW'(NOTE_TOL));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_measure   = 1'b0;
    w_check_tol = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_SILENT: begin
        if (w_edge) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_edge) begin
          w_state_nxt = ST_MEASURING;
          w_measure   = 1'b1;
        end else if (w_at_limit) begin
          w_state_nxt = ST_SILENT;
          w_timeout   = 1'b1;
        end
      end
      ST_MEASURING: begin
        if (w_edge) begin
          w_measure   = 1'b1;
          w_check_tol = 1'b1;
        end else if (w_at_limit) begin
          w_state_nxt = ST_SILENT;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = ST_SILENT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SILENT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_cnt    <= '0;
      r_prev   <= '0;
      r_half   <= '0;
      r_valid  <= 1'b0;
      r_stable <= 1'b0;
      r_silent <= 1'b1;
      r_note   <= 1'b0;
      r_edges  <= '0;
    end else begin
      r_s1    <= bus.tone_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= w_measure;

      if (w_edge) begin
        r_cnt   <= CW'(1);
        r_edges <= r_edges + 1'b1;
      end else if (w_timeout || r_state == ST_SILENT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_SILENT && w_edge) r_silent <= 1'b0;

      // note_a uses the freshly computed stability so both flags move together.
      if (w_measure) begin
        r_half   <= r_cnt;
        r_prev   <= r_cnt;
        r_stable <= w_new_stable;
        r_note   <= w_new_stable && w_in_window;
      end

      if (w_timeout) begin
        r_silent <= 1'b1;
        r_stable <= 1'b0;
        r_note   <= 1'b0;
      end
    end
  end

  assign bus.half_period = r_half;
  assign bus.meas_valid  = r_valid;
  assign bus.stable      = r_stable;
  assign bus.silent      = r_silent;
  assign bus.note_a      = r_note;
  assign bus.edge_count  = r_edges;
endmodule

// File: tb/tb_tone_meter.sv
// Scoreboard bench for tone_meter with scaled-down timing parameters; expected
// measurements come from toggle timestamps, a monitor compares on meas_valid.
module tb_tone_meter;
  localparam int TIMEOUT   = 2000;
  localparam int TOL       = 8;
  localparam int NOTE_HALF = 400;
  localparam int NOTE_TOL  = 10;
  localparam int EC_W      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tone_meter_if #(.EC_W(EC_W)) bus ();

  tone_meter #(
    .TIMEOUT(TIMEOUT), .TOL(TOL), .NOTE_HALF(NOTE_HALF),
    .NOTE_TOL(NOTE_TOL), .EC_W(EC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int hp;
    bit st;
    bit na;
    int ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: a tone is described only by when its transitions happened.
  bit m_armed;
  bit m_have_meas;
  int m_last_cyc;
  int m_last;
  int m_edges;
  int m_hp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic check(string name, int act, int expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_armed     = 1'b0;
    m_have_meas = 1'b0;
    m_last_cyc  = 0;
    m_last      = 0;
    m_edges     = 0;
    m_hp        = 0;
    exp_q.delete();
  endtask

  task automatic model_toggle();
    int   gap;
    exp_t e;
    m_edges++;
    gap = cyc - m_last_cyc;
    if (m_armed && gap <= TIMEOUT) begin
      e.hp = gap;
      e.st = m_have_meas && (iabs(gap - m_last) <= TOL);
      e.na = e.st && (iabs(gap - NOTE_HALF) <= NOTE_TOL);
      e.ec = m_edges % (1 << EC_W);
      exp_q.push_back(e);
      m_last      = gap;
      m_hp        = gap;
      m_have_meas = 1'b1;
    end else begin
      m_have_meas = 1'b0;
    end
    m_armed    = 1'b1;
    m_last_cyc = cyc;
  endtask

  task automatic toggle(int d);
    repeat (d) @(posedge clk);
    #1;
    bus.tone_in = ~bus.tone_in;
    model_toggle();
  endtask

  task automatic idle(int d);
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, " half_period"}, int'(bus.half_period), 0);
    check({tag, " meas_valid"},  int'(bus.meas_valid),  0);
    check({tag, " stable"},      int'(bus.stable),      0);
    check({tag, " silent"},      int'(bus.silent),      1);
    check({tag, " note_a"},      int'(bus.note_a),      0);
    check({tag, " edge_count"},  int'(bus.edge_count),  0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.tone_in = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    idle(3);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.meas_valid === 1'b1) begin
      check("meas_valid expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("half_period", int'(bus.half_period), e.hp);
        check("stable",      int'(bus.stable),      int'(e.st));
        check("note_a",      int'(bus.note_a),      int'(e.na));
        check("edge_count",  int'(bus.edge_count),  e.ec);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int jit;
    bus.tone_in = 1'b0;
    model_reset();
    rst = 1'b1;
    idle(3);
    check_reset_outputs("power-on");
    rst = 1'b0;

    // Line held low well past the timeout: still silent, nothing counted.
    idle(2 * TIMEOUT);
    check("idle silent", int'(bus.silent), 1);
    check("idle edge_count", int'(bus.edge_count), 0);

    // Concert A: first edge arms, second measures unstable, third is stable note A.
    toggle(7);
    idle(5);
    check("armed silent", int'(bus.silent), 0);
    check("armed no measurement", int'(bus.half_period), 0);
    for (int i = 0; i < 3; i++) toggle(NOTE_HALF);

    // Pitch jump to the octave above, then tolerance boundaries.
    for (int i = 0; i < 3; i++) toggle(NOTE_HALF / 2);
    toggle(100); toggle(108); toggle(100); toggle(109);

    // Note window boundaries on both sides.
    toggle(NOTE_HALF + NOTE_TOL);     toggle(NOTE_HALF + NOTE_TOL);
    toggle(NOTE_HALF + NOTE_TOL + 1); toggle(NOTE_HALF + NOTE_TOL + 1);
    toggle(NOTE_HALF - NOTE_TOL);     toggle(NOTE_HALF - NOTE_TOL);
    toggle(NOTE_HALF - NOTE_TOL - 1); toggle(NOTE_HALF - NOTE_TOL - 1);

    // Reset in the middle of a running tone.
    toggle(200); toggle(200);
    idle(50);
    do_reset();
    idle(20);

    // Edge exactly at the timeout is a measurement; one cycle later is silence.
    toggle(5); toggle(300); toggle(300);
    toggle(TIMEOUT);
    idle(5);
    check("edge at timeout silent", int'(bus.silent), 0);
    idle(TIMEOUT + 10);
    check("timeout silent", int'(bus.silent), 1);
    check("timeout stable", int'(bus.stable), 0);
    check("timeout note_a", int'(bus.note_a), 0);
    check("timeout half_period kept", int'(bus.half_period), m_hp);
    toggle(3); toggle(250); toggle(TIMEOUT + 1); toggle(250); toggle(250);

    // Randomised tones with jitter around TOL, some around note A, one after silence.
    for (int r = 0; r < 5; r++) begin
      base = (r % 2 == 0) ? NOTE_HALF : int'($urandom_range(20, 500));
      if (r == 3) idle(TIMEOUT + int'($urandom_range(1, 50)));
      for (int i = 0; i < 10; i++) begin
        jit = int'($urandom_range(0, 2 * TOL + 2)) - (TOL + 1);
        toggle(base + jit);
      end
    end

    // Edge counter wrap: 2^EC_W + 1 edges after reset leaves a count of 1.
    do_reset();
    idle(10);
    for (int i = 0; i < (1 << EC_W) + 1; i++) toggle(1);
    idle(10);
    check("edge_count wrap", int'(bus.edge_count), m_edges % (1 << EC_W));
    check("edge_count wrap value", int'(bus.edge_count), 1);

    idle(10);
    check("all measurements seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
